rom_dl_packer: RTL and testbench

ROM_DL_PACKER -- requirements
Module: rom_dl_packer

---
 rtl/armedf_pkg.sv | 28 ++
 rtl/rom_dl_fifo.sv | 60 ++++++
 rtl/rom_dl_packer.sv | 144 ++++++++++++++
 tb/tb_rom_dl_packer.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/armedf_pkg.sv
// Shared types for the ROM download path: writer FSM states, the queued
// SDRAM word entry and the byte-lane packing helper.
package armedf_pkg;

  // Widest word address an entry can carry; narrower streams zero-extend.
  localparam int unsigned DL_WADDR_MAX = 32;

  typedef enum logic {
    IDLE,
    BUSY
  } wr_state_t;

  typedef struct packed {
    logic [DL_WADDR_MAX-1:0] addr;
    logic [15:0]             data;
    logic [1:0]              be;
  } dl_entry_t;

  // Place one byte on its 16-bit lane; returns {data, be}.
  // Upper lane is taken by even bytes in big-endian mode, odd bytes otherwise.
  function automatic logic [17:0] lane_word(input logic [7:0] b,
                                            input logic       lane,
                                            input logic       big_endian);
    if (lane ^ big_endian) lane_word = {b, 8'h00, 2'b10};
    else                   lane_word = {8'h00, b, 2'b01};
  endfunction

endpackage

// File: rtl/rom_dl_fifo.sv
// Synchronous FIFO of packed download words with registered full/empty.
module rom_dl_fifo
  import armedf_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  dl_entry_t push_data,
  input  logic      pop,
  output dl_entry_t head,
  output logic      full,
  output logic      empty
);

  localparam int unsigned    PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  dl_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic [PTR_W:0]   count_next;
  logic             do_push;
  logic             do_pop;

  // A push while full is only taken when a pop frees the slot in the same cycle.
  always_comb begin
    do_pop     = pop & ~empty;
    do_push    = push & (~full | do_pop);
    count_next = count;
    if (do_push && !do_pop)      count_next = count + 1'b1;
    else if (!do_push && do_pop) count_next = count - 1'b1;
    head = mem[rd_ptr];
  end

  // Storage array, written at the tail.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers, occupancy and registered flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      full  <= (count_next == FULL_CNT);
      empty <= (count_next == '0);
    end
  end

endmodule

// File: rtl/rom_dl_packer.sv
// Packs the ioctl byte download stream into 16-bit SDRAM words, queues them
// and issues them over a toggle req/ack handshake; tracks load completion.
module rom_dl_packer
  import armedf_pkg::*;
#(
  parameter int unsigned ADDR_W     = 25,
  parameter int unsigned BIG_ENDIAN = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk_96M,
  input  logic              reset,
  input  logic              rom_download,
  input  logic              ioctl_wr,
  input  logic [ADDR_W-1:0] ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              sd_req,
  input  logic              sd_ack,
  output logic [ADDR_W-2:0] sd_addr,
  output logic [15:0]       sd_data,
  output logic [1:0]        sd_be,
  output logic              rom_loaded,
  output logic              core_reset,
  output logic              overflow
);

  localparam logic BE_MODE = (BIG_ENDIAN != 0);

  logic              wr_eff;
  logic              dl_d;
  logic              flush_q;
  logic              seen_dl;
  logic              pend_valid;
  logic              pend_lane;
  logic [ADDR_W-2:0] pend_waddr;
  logic [7:0]        pend_data;
  logic [ADDR_W-2:0] in_waddr;
  logic              in_lane;
  logic              pairs;
  logic [17:0]       pend_word;
  logic [17:0]       in_word;
  logic              push;
  logic              pop;
  dl_entry_t         push_entry;
  dl_entry_t         head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              drained;
  wr_state_t         state;

  rom_dl_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_96M),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Pair the incoming byte with the pending one, or evict the pending byte
  // as a partial word; a scheduled flush evicts it without a new byte.
  always_comb begin
    wr_eff     = ioctl_wr & rom_download;
    in_waddr   = ioctl_addr[ADDR_W-1:1];
    in_lane    = ioctl_addr[0];
    pairs      = pend_valid & (in_waddr == pend_waddr) & (in_lane != pend_lane);
    pend_word  = lane_word(pend_data, pend_lane, BE_MODE);
    in_word    = lane_word(ioctl_dout, in_lane, BE_MODE);
    push       = 1'b0;
    push_entry = '0;
    if (pend_valid && (wr_eff || flush_q)) begin
      push            = 1'b1;
      push_entry.addr = DL_WADDR_MAX'(pend_waddr);
      {push_entry.data, push_entry.be} = (wr_eff && pairs) ? (pend_word | in_word) : pend_word;
    end
    pop     = (state == IDLE) & ~fifo_empty;
    drained = fifo_empty & ~pend_valid & (state == IDLE) & ~flush_q;
  end

  // Pending-byte slot and download falling-edge flush scheduling.
  always_ff @(posedge clk_96M) begin
    if (reset) begin
      pend_valid <= 1'b0;
      pend_lane  <= 1'b0;
      pend_waddr <= '0;
      pend_data  <= '0;
      dl_d       <= 1'b0;
      flush_q    <= 1'b0;
    end else begin
      dl_d    <= rom_download;
      flush_q <= dl_d & ~rom_download;
      if (wr_eff) begin
        pend_valid <= ~pairs;
        pend_waddr <= in_waddr;
        pend_lane  <= in_lane;
        pend_data  <= ioctl_dout;
      end else if (flush_q) begin
        pend_valid <= 1'b0;
      end
    end
  end

  // Writer FSM: launch the FIFO head with a req toggle, wait for the echo.
  always_ff @(posedge clk_96M) begin
    if (reset) begin
      state   <= IDLE;
      sd_req  <= 1'b0;
      sd_addr <= '0;
      sd_data <= '0;
      sd_be   <= '0;
    end else begin
      case (state)
        IDLE: if (!fifo_empty) begin
          sd_req  <= ~sd_req;
          sd_addr <= (ADDR_W-1)'(head.addr);
          sd_data <= head.data;
          sd_be   <= head.be;
          state   <= BUSY;
        end
        BUSY: if (sd_ack == sd_req) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky completion/overflow flags and the registered core reset request.
  always_ff @(posedge clk_96M) begin
    if (reset) begin
      seen_dl    <= 1'b0;
      rom_loaded <= 1'b0;
      overflow   <= 1'b0;
      core_reset <= 1'b1;
    end else begin
      seen_dl <= seen_dl | rom_download;
      if (seen_dl && !rom_download && drained) rom_loaded <= 1'b1;
      if (push && fifo_full && !pop)           overflow   <= 1'b1;
      core_reset <= ~rom_loaded | rom_download | ~drained;
    end
  end

endmodule

// File: tb/tb_rom_dl_packer.sv
// Bench for rom_dl_packer: byte-stream model predicting the SDRAM word writes,
// a toggle-handshake SDRAM responder that scores every launch, plus directed
// checks of reset, endianness, flush, overflow and load-completion timing.
module tb_rom_dl_packer;

  localparam int unsigned AW = 25;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          rom_download = 1'b0;
  logic          ioctl_wr = 1'b0;
  logic [AW-1:0] ioctl_addr = '0;
  logic [7:0]    ioctl_dout = '0;
  logic          sd_req;
  logic          sd_ack = 1'b0;
  logic [AW-2:0] sd_addr;
  logic [15:0]   sd_data;
  logic [1:0]    sd_be;
  logic          rom_loaded;
  logic          core_reset;
  logic          overflow;

  rom_dl_packer #(
    .ADDR_W     (AW),
    .BIG_ENDIAN (1),
    .FIFO_DEPTH (4)
  ) dut (
    .clk_96M      (clk),
    .reset        (reset),
    .rom_download (rom_download),
    .ioctl_wr     (ioctl_wr),
    .ioctl_addr   (ioctl_addr),
    .ioctl_dout   (ioctl_dout),
    .sd_req       (sd_req),
    .sd_ack       (sd_ack),
    .sd_addr      (sd_addr),
    .sd_data      (sd_data),
    .sd_be        (sd_be),
    .rom_loaded   (rom_loaded),
    .core_reset   (core_reset),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned addr;
    logic [15:0] data;
    logic [1:0]  be;
  } wr_t;

  wr_t expq[$];
  wr_t wlog[$];

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural byte->word model ----------------
  bit          m_valid = 0;
  int unsigned m_w;
  bit          m_l;
  logic [7:0]  m_d;

  task automatic m_push_partial();
    wr_t e;
    e.addr = m_w;
    if (m_l == 0) begin e.data = {m_d, 8'h00}; e.be = 2'b10; end
    else          begin e.data = {8'h00, m_d}; e.be = 2'b01; end
    expq.push_back(e);
  endtask

  task automatic model_byte(input int unsigned a, input logic [7:0] d);
    int unsigned w;
    bit l;
    wr_t e;
    w = a / 2;
    l = a[0];
    if (m_valid && w == m_w && l != m_l) begin
      e.addr = w;
      e.data = (l == 1) ? {m_d, d} : {d, m_d};
      e.be   = 2'b11;
      expq.push_back(e);
      m_valid = 0;
    end else begin
      if (m_valid) m_push_partial();
      m_valid = 1; m_w = w; m_l = l; m_d = d;
    end
  endtask

  // ---------------- SDRAM responder / scoreboard ----------------
  bit          ack_hold = 0;
  int unsigned ack_dly = 3;   // 0 selects a random 1..3 cycle delay
  bit          outstanding = 0;
  bit          prev_req = 0;
  int unsigned cnt = 0;
  logic [AW+16:0] held;

  always @(negedge clk) begin
    if (reset) begin
      sd_ack = 1'b0;
      prev_req = sd_req;
      outstanding = 0;
    end else if (sd_req != prev_req) begin
      wr_t e;
      chk("toggle_while_busy", outstanding, 0);
      prev_req = sd_req;
      e.addr = sd_addr; e.data = sd_data; e.be = sd_be;
      wlog.push_back(e);
      chk("write_expected", expq.size() != 0, 1);
      if (expq.size() != 0) begin
        chk("wr_addr", sd_addr, expq[0].addr);
        chk("wr_data", sd_data, expq[0].data);
        chk("wr_be",   sd_be,   expq[0].be);
        void'(expq.pop_front());
      end
      held = {sd_addr, sd_data, sd_be};
      outstanding = 1;
      cnt = (ack_dly == 0) ? $urandom_range(1, 3) : ack_dly;
    end else if (outstanding) begin
      chk("wr_stable", {sd_addr, sd_data, sd_be}, held);
      if (!ack_hold) begin
        cnt--;
        if (cnt == 0) begin
          sd_ack = sd_req;
          outstanding = 0;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk); #1;
  endtask

  task automatic send(input int unsigned a, input logic [7:0] d);
    ioctl_addr = AW'(a);
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    if (rom_download) model_byte(a, d);
    tick();
    ioctl_wr = 1'b0;
  endtask

  task automatic end_dl();
    rom_download = 1'b0;
    if (m_valid) begin m_push_partial(); m_valid = 0; end
    tick();
  endtask

  task automatic chk_reset_state();
    chk("rst_sd_req",     sd_req, 0);
    chk("rst_sd_addr",    sd_addr, 0);
    chk("rst_sd_data",    sd_data, 0);
    chk("rst_sd_be",      sd_be, 0);
    chk("rst_rom_loaded", rom_loaded, 0);
    chk("rst_overflow",   overflow, 0);
    chk("rst_core_reset", core_reset, 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rom_download = 1'b0;
    ioctl_wr = 1'b0;
    expq.delete();
    m_valid = 0;
    tick(); tick();
    smp();
    chk_reset_state();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_writes(input string name, input int unsigned n, input int unsigned maxc);
    bit ok = 0;
    for (int unsigned i = 0; i < maxc; i++) begin
      smp();
      if (wlog.size() >= n && !outstanding) begin ok = 1; break; end
    end
    chk(name, ok, 1);
  endtask

  task automatic wait_drain(input string name, input int unsigned maxc);
    bit ok = 0;
    for (int unsigned i = 0; i < maxc; i++) begin
      smp();
      if (expq.size() == 0 && !outstanding) begin ok = 1; break; end
    end
    chk(name, ok, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int unsigned a;
    int unsigned nlog;
    bit ok;

    do_reset();

    // Full word from an even/odd pair, ack after 3 cycles.
    ack_dly = 3;
    wlog.delete();
    rom_download = 1'b1;
    tick();
    send(0, 8'h12);
    send(1, 8'h34);
    wait_writes("pair_wait", 1, 40);
    chk("pair_count", wlog.size(), 1);
    if (wlog.size() >= 1) begin
      chk("pair_addr", wlog[0].addr, 0);
      chk("pair_data", wlog[0].data, 16'h1234);
      chk("pair_be",   wlog[0].be, 2'b11);
    end
    smp();
    chk("dl_rom_loaded_low", rom_loaded, 0);
    chk("dl_core_reset_high", core_reset, 1);

    // Two unpaired bytes; the second is flushed when the download falls.
    wlog.delete();
    send(4, 8'hAA);
    send(9, 8'hBB);
    end_dl();
    wait_writes("flush_wait", 2, 40);
    chk("flush_count", wlog.size(), 2);
    if (wlog.size() >= 2) begin
      chk("flush0_addr", wlog[0].addr, 2);
      chk("flush0_data", wlog[0].data, 16'hAA00);
      chk("flush0_be",   wlog[0].be, 2'b10);
      chk("flush1_addr", wlog[1].addr, 4);
      chk("flush1_data", wlog[1].data, 16'h00BB);
      chk("flush1_be",   wlog[1].be, 2'b01);
    end
    ok = 0;
    for (int unsigned i = 0; i < 60; i++) begin
      smp();
      if (rom_loaded) begin ok = 1; break; end
    end
    chk("loaded_after_dl", ok, 1);
    tick(); tick();
    smp();
    chk("core_reset_released", core_reset, 0);

    // Writes outside a download are ignored.
    nlog = wlog.size();
    send(16'h100, 8'h55);
    repeat (10) tick();
    smp();
    chk("ignored_wr", wlog.size(), nlog);

    // Re-download with randomized bytes and handshake latency.
    rom_download = 1'b1;
    tick();
    smp();
    chk("redl_core_reset", core_reset, 1);
    chk("redl_rom_loaded", rom_loaded, 1);
    ack_dly = 0;
    a = $urandom_range(0, 1000);
    for (int unsigned i = 0; i < 160; i++) begin
      case ($urandom_range(0, 7))
        0:       a = a + $urandom_range(2, 40);
        1:       a = a;
        default: a = a + 1;
      endcase
      a = a & ((1 << AW) - 1);
      send(a, 8'($urandom));
      repeat ($urandom_range(5, 7)) tick();
    end
    end_dl();
    wait_drain("rand_drain", 300);
    repeat (5) tick();
    smp();
    chk("rand_queue_empty", expq.size(), 0);
    chk("rand_overflow",    overflow, 0);
    chk("rand_rom_loaded",  rom_loaded, 1);
    chk("rand_core_reset",  core_reset, 0);

    // Load completion timing: download ends with two words still queued.
    do_reset();
    wlog.delete();
    ack_dly = 2;
    ack_hold = 1;
    rom_download = 1'b1;
    tick();
    for (int unsigned i = 0; i < 6; i++) send(i, 8'($urandom));
    end_dl();
    repeat (6) tick();
    smp();
    chk("tail_first_launch", wlog.size(), 1);
    chk("tail_not_loaded", rom_loaded, 0);
    ack_hold = 0;
    wait_writes("tail_wait", 3, 60);
    chk("tail_loaded_at_ack", rom_loaded, 0);
    smp();
    chk("tail_loaded_ack_p1", rom_loaded, 0);
    smp();
    chk("tail_loaded_ack_p2", rom_loaded, 1);
    chk("tail_core_reset_p2", core_reset, 1);
    smp();
    chk("tail_core_reset_p3", core_reset, 0);
    chk("tail_count", wlog.size(), 3);

    // Overflow: eight back-to-back pairs with the ack withheld.
    do_reset();
    wlog.delete();
    ack_dly = 2;
    ack_hold = 1;
    rom_download = 1'b1;
    tick();
    for (int unsigned i = 0; i < 16; i++) send(i, 8'($urandom));
    repeat (40) tick();
    smp();
    chk("ovf_flag", overflow, 1);
    chk("ovf_single_toggle", wlog.size(), 1);
    chk("ovf_model_backlog", expq.size(), 7);
    ack_hold = 0;
    wait_writes("ovf_wait", 5, 80);
    repeat (10) tick();
    smp();
    chk("ovf_launches", wlog.size(), 5);
    chk("ovf_dropped", expq.size(), 3);
    expq.delete();

    // Reset while the writer is waiting for an ack.
    wlog.delete();
    ack_hold = 1;
    m_valid = 0;
    send(40, 8'h5A);
    send(41, 8'hA5);
    ok = 0;
    for (int unsigned i = 0; i < 10; i++) begin
      smp();
      if (wlog.size() == 1) begin ok = 1; break; end
    end
    chk("busy_launch", ok, 1);
    reset = 1'b1;
    rom_download = 1'b0;
    expq.delete();
    tick();
    smp();
    chk("busyrst_sd_req",     sd_req, 0);
    chk("busyrst_rom_loaded", rom_loaded, 0);
    chk("busyrst_core_reset", core_reset, 1);
    chk("busyrst_overflow",   overflow, 0);
    tick();
    reset = 1'b0;
    ack_hold = 0;
    repeat (10) tick();
    smp();
    chk("busyrst_no_launch", wlog.size(), 1);
    chk("busyrst_sd_req_idle", sd_req, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
